light_sequencer: RTL

- Phase controller that sits directly downstream of the programmable beat timer and is its only consumer.
- Drives the timer's load value and a restart strobe, and waits for the timer's done flag to advance the phase.
- Phase order: green -> yellow -> red -> (walk if requested) -> green.
- Outputs are registered light/walk enables for the board LED driver.

---
 rtl/light_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/light_sequencer.sv
// Phase controller for the traffic light: walks green/yellow/red(/walk) and
// drives the beat timer's load value and restart strobe, advancing on a fresh done.
module light_sequencer #(
  parameter logic [7:0] GREEN_TIME  = 8'd10,
  parameter logic [7:0] YELLOW_TIME = 8'd3,
  parameter logic [7:0] RED_TIME    = 8'd8,
  parameter logic [7:0] WALK_TIME   = 8'd6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       walk_req,
  input  logic       timer_done,
  output logic [7:0] timer_load,
  output logic       timer_restart,
  output logic       light_g,
  output logic       light_y,
  output logic       light_r,
  output logic       walk_on,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_RED    = 2'd2,
    PH_WALK   = 2'd3
  } phase_t;

  // A zero load would never produce a rising done, so it is treated as one beat.
  localparam logic [7:0] LOAD_G = (GREEN_TIME  == 8'd0) ? 8'd1 : GREEN_TIME;
  localparam logic [7:0] LOAD_Y = (YELLOW_TIME == 8'd0) ? 8'd1 : YELLOW_TIME;
  localparam logic [7:0] LOAD_R = (RED_TIME    == 8'd0) ? 8'd1 : RED_TIME;
  localparam logic [7:0] LOAD_W = (WALK_TIME   == 8'd0) ? 8'd1 : WALK_TIME;

  phase_t     r_phase;
  logic [7:0] r_load;
  logic       r_restart;
  logic       r_lightG;
  logic       r_lightY;
  logic       r_lightR;
  logic       r_walkOn;
  logic       r_walkPending;
  logic       r_armed;
  logic       r_seenLow;

  logic       w_expire;
  logic       w_walkGo;

  // Only a done that rises after this phase's restart counts as expiry.
  assign w_expire = r_armed & r_seenLow & timer_done;
  assign w_walkGo = r_walkPending | walk_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase       <= PH_GREEN;
      r_load        <= LOAD_G;
      r_restart     <= 1'b1;
      r_lightG      <= 1'b1;
      r_lightY      <= 1'b0;
      r_lightR      <= 1'b0;
      r_walkOn      <= 1'b0;
      r_walkPending <= 1'b0;
      r_armed       <= 1'b0;
      r_seenLow     <= 1'b0;
    end else begin
      r_restart <= 1'b0;
      if (walk_req && (r_phase != PH_WALK)) begin
        r_walkPending <= 1'b1;
      end
      if (r_restart) begin
        r_armed   <= 1'b1;
        r_seenLow <= 1'b0;
      end else if (w_expire) begin
        r_armed   <= 1'b0;
        r_seenLow <= 1'b0;
        r_restart <= 1'b1;
        case (r_phase)
          PH_GREEN: begin
            r_phase  <= PH_YELLOW;
            r_load   <= LOAD_Y;
            r_lightG <= 1'b0;
            r_lightY <= 1'b1;
            r_lightR <= 1'b0;
            r_walkOn <= 1'b0;
          end
          PH_YELLOW: begin
            r_phase  <= PH_RED;
            r_load   <= LOAD_R;
            r_lightG <= 1'b0;
            r_lightY <= 1'b0;
            r_lightR <= 1'b1;
            r_walkOn <= 1'b0;
          end
          PH_RED: begin
            r_lightG <= ~w_walkGo;
            r_lightY <= 1'b0;
            r_lightR <= w_walkGo;
            r_walkOn <= w_walkGo;
            if (w_walkGo) begin
              r_phase <= PH_WALK;
              r_load  <= LOAD_W;
            end else begin
              r_phase <= PH_GREEN;
              r_load  <= LOAD_G;
            end
          end
          PH_WALK: begin
            r_phase       <= PH_GREEN;
            r_load        <= LOAD_G;
            r_lightG      <= 1'b1;
            r_lightY      <= 1'b0;
            r_lightR      <= 1'b0;
            r_walkOn      <= 1'b0;
            r_walkPending <= 1'b0;
          end
        endcase
      end else if (r_armed && !timer_done) begin
        r_seenLow <= 1'b1;
      end
    end
  end

  assign timer_load    = r_load;
  assign timer_restart = r_restart;
  assign light_g       = r_lightG;
  assign light_y       = r_lightY;
  assign light_r       = r_lightR;
  assign walk_on       = r_walkOn;
  assign phase         = r_phase;

endmodule
